// File: rtl/fifo_uart_tx_if.sv
// FIFO-read and serial-line signals of the UART transmitter.
// The master modport is the transmitter; the slave side is the FIFO, tick source and line.
interface fifo_uart_tx_if #(
   parameter int DBIT = 8
);
   logic            s_tick;
   logic            fifo_empty;
   logic [DBIT-1:0] fifo_rdata;
   logic            fifo_rd;
   logic            tx;
   logic            tx_busy;
   logic            tx_done_tick;

   modport master (
      input  s_tick, fifo_empty, fifo_rdata,
      output fifo_rd, tx, tx_busy, tx_done_tick
   );

   modport slave (
      output s_tick, fifo_empty, fifo_rdata,
      input  fifo_rd, tx, tx_busy, tx_done_tick
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO: start bit, DBIT data bits
// LSB first, then a stop period of SB_TICK oversampling ticks.
module fifo_uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic           clk,
   input  logic           reset,
   fifo_uart_tx_if.master bus
);
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0] S_LAST    = SW'(15);
   localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic [SW-1:0]   s_cnt, s_cnt_n;
   logic [NW-1:0]   n_cnt, n_cnt_n;
   logic [DBIT-1:0] b_reg, b_reg_n;
   logic            tx_reg, tx_n;
   logic            pop, done;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         s_cnt  <= '0;
         n_cnt  <= '0;
         b_reg  <= '0;
         tx_reg <= 1'b1;
      end else begin
         state  <= state_n;
         s_cnt  <= s_cnt_n;
         n_cnt  <= n_cnt_n;
         b_reg  <= b_reg_n;
         tx_reg <= tx_n;
      end
   end

   // tx_n is the line level for the current state; registering it gives a
   // glitch-free pin that trails each state/bit transition by one clk.
   always_comb begin
      state_n = state;
      s_cnt_n = s_cnt;
      n_cnt_n = n_cnt;
      b_reg_n = b_reg;
      tx_n    = 1'b1;
      pop     = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            // s_tick is deliberately ignored here so START always spans 16 full ticks
            if (!bus.fifo_empty) begin
               pop     = 1'b1;
               b_reg_n = bus.fifo_rdata;
               s_cnt_n = '0;
               state_n = START;
            end
         end
         START: begin
            tx_n = 1'b0;
            if (bus.s_tick) begin
               if (s_cnt == S_LAST) begin
                  s_cnt_n = '0;
                  n_cnt_n = '0;
                  state_n = DATA;
               end else begin
                  s_cnt_n = s_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            tx_n = b_reg[0];
            if (bus.s_tick) begin
               if (s_cnt == S_LAST) begin
                  s_cnt_n = '0;
                  b_reg_n = b_reg >> 1;
                  if (n_cnt == N_LAST) state_n = STOP;
                  else                 n_cnt_n = n_cnt + 1'b1;
               end else begin
                  s_cnt_n = s_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (bus.s_tick) begin
               if (s_cnt == STOP_LAST) begin
                  done    = 1'b1;
                  state_n = IDLE;
               end else begin
                  s_cnt_n = s_cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Strobes are masked by reset so a reset cycle can neither pop nor complete a frame.
   assign bus.fifo_rd      = pop & reset;
   assign bus.tx_done_tick = done & reset;
   assign bus.tx_busy      = (state != IDLE);
   assign bus.tx           = tx_reg;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a FIFO model feeds two instances (8N1 and 7-bit/2-stop),
// a line monitor decodes each frame at mid-bit and counts its ticks.
module tb_fifo_uart_tx;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       s_tick  = 1'b0;
   logic       tick_en = 1'b0;
   logic       a_empty = 1'b1;
   logic [7:0] a_rdata = 8'hC3;
   logic       b_empty = 1'b1;
   logic [6:0] b_rdata = 7'h2A;

   fifo_uart_tx_if #(.DBIT(8)) ia ();
   fifo_uart_tx_if #(.DBIT(7)) ib ();

   assign ia.s_tick     = s_tick;
   assign ia.fifo_empty = a_empty;
   assign ia.fifo_rdata = a_rdata;
   assign ib.s_tick     = s_tick;
   assign ib.fifo_empty = b_empty;
   assign ib.fifo_rdata = b_rdata;

   fifo_uart_tx #(.DBIT(8), .SB_TICK(16)) dut_a (.clk(clk), .reset(reset), .bus(ia.master));
   fifo_uart_tx #(.DBIT(7), .SB_TICK(32)) dut_b (.clk(clk), .reset(reset), .bus(ib.master));

   typedef struct {
      logic [15:0] bits;
      int          ticks;
      logic        stop_bad;
   } frm_t;

   typedef struct {
      logic [7:0] d;
      logic [9:0] frame;
      int         ticks;
   } vec_t;

   logic [7:0] qa[$];
   logic [6:0] qb[$];
   frm_t       fq_a[$];
   frm_t       fq_b[$];
   int         pops[2];
   int         dones[2];
   int         cnt[2];
   logic       pend[2];
   int         nvec = 0;
   int         nbad = 0;

   // Empty FIFO presents junk on rdata so a late capture would show up in the frame.
   task automatic upd();
      a_empty = (qa.size() == 0);
      a_rdata = a_empty ? 8'hC3 : qa[0];
      b_empty = (qb.size() == 0);
      b_rdata = b_empty ? 7'h2A : qb[0];
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // s_tick every 4th clk, changed just after the rising edge
   initial begin
      int div;
      div = 0;
      forever begin
         @(posedge clk); #1;
         div = (div + 1) % 4;
         s_tick = tick_en && (div == 0);
      end
   end

   // FIFO pop lands after the edge that consumed the head word
   initial begin
      forever begin
         @(posedge clk); #1;
         if (pend[0]) void'(qa.pop_front());
         if (pend[1]) void'(qb.pop_front());
         if (pend[0] || pend[1]) upd();
      end
   end

   // Line monitor: counts busy ticks, samples tx at tick 8 of every 16
   initial begin
      logic [15:0] bits[2];
      logic        sbad[2];
      logic        busy[2], txv[2], rd[2], dn[2];
      int          sb_from[2];
      frm_t        nf;
      sb_from[0] = 144;
      sb_from[1] = 128;
      for (int k = 0; k < 2; k++) begin
         pops[k] = 0; dones[k] = 0; cnt[k] = 0; pend[k] = 1'b0;
         bits[k] = '0; sbad[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         busy[0] = ia.tx_busy; txv[0] = ia.tx; rd[0] = ia.fifo_rd; dn[0] = ia.tx_done_tick;
         busy[1] = ib.tx_busy; txv[1] = ib.tx; rd[1] = ib.fifo_rd; dn[1] = ib.tx_done_tick;
         for (int k = 0; k < 2; k++) begin
            if (rd[k] === 1'b1) pops[k]++;
            if (dn[k] === 1'b1) dones[k]++;
            pend[k] = (rd[k] === 1'b1);
            if (!reset) begin
               cnt[k] = 0; bits[k] = '0; sbad[k] = 1'b0;
            end else begin
               if (busy[k] === 1'b1 && s_tick) begin
                  cnt[k]++;
                  if (cnt[k] % 16 == 8 && cnt[k] / 16 < 16) bits[k][cnt[k] / 16] = txv[k];
                  if (cnt[k] > sb_from[k] && txv[k] !== 1'b1) sbad[k] = 1'b1;
               end
               if (dn[k] === 1'b1) begin
                  nf.bits = bits[k]; nf.ticks = cnt[k]; nf.stop_bad = sbad[k];
                  if (k == 0) fq_a.push_back(nf);
                  else        fq_b.push_back(nf);
                  cnt[k] = 0; bits[k] = '0; sbad[k] = 1'b0;
               end
            end
         end
      end
   end

   task automatic wait_frames(input int k, input int n, output logic ok);
      int t;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (((k == 0) ? fq_a.size() : fq_b.size()) < n && t < 3000 * n);
      ok = (((k == 0) ? fq_a.size() : fq_b.size()) >= n);
   endtask

   task automatic wait_cnt(input int n, output logic ok);
      int t;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (cnt[0] < n && t < 4000);
      ok = (cnt[0] >= n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[4];
      frm_t f;
      logic ok;
      int   p0, d0, bad, t, rd_mid;

      tbl[0] = '{d: 8'hA5, frame: 10'h34A, ticks: 160};
      tbl[1] = '{d: 8'h00, frame: 10'h200, ticks: 160};
      tbl[2] = '{d: 8'hFF, frame: 10'h3FE, ticks: 160};
      tbl[3] = '{d: 8'h3C, frame: 10'h278, ticks: 160};

      // reset held with a word waiting: nothing may move
      qa.push_back(8'h99); upd();
      repeat (3) begin
         @(negedge clk);
         chk("rst_rd",   32'(ia.fifo_rd), 0);
         chk("rst_tx",   32'(ia.tx), 1);
         chk("rst_busy", 32'(ia.tx_busy), 0);
      end
      @(posedge clk); #1;
      qa.delete(); upd();
      reset = 1'b1; tick_en = 1'b1;

      // single words, one frame each
      for (int i = 0; i < 4; i++) begin
         p0 = pops[0]; d0 = dones[0];
         @(posedge clk); #1;
         qa.push_back(tbl[i].d); upd();
         wait_frames(0, 1, ok);
         chk("tbl_timeout", 32'(ok), 1);
         if (ok) begin
            f = fq_a.pop_front();
            chk("tbl_frame", 32'(f.bits[9:0]), 32'(tbl[i].frame));
            chk("tbl_ticks", f.ticks, tbl[i].ticks);
            chk("tbl_stop",  32'(f.stop_bad), 0);
         end
         chk("tbl_pops",  pops[0] - p0, 1);
         chk("tbl_dones", dones[0] - d0, 1);
      end

      // back-to-back: two words queued, a third written mid-frame
      p0 = pops[0]; d0 = dones[0];
      @(posedge clk); #1;
      qa.push_back(8'h00); qa.push_back(8'hFF); upd();
      wait_cnt(50, ok);
      chk("b2b_cnt_timeout", 32'(ok), 1);
      qa.push_back(8'h3C); upd();
      for (int j = 0; j < 2; j++) begin
         t = 0; rd_mid = 0;
         do begin
            @(negedge clk);
            t++;
            if (ia.fifo_rd === 1'b1) rd_mid++;
         end while (ia.tx_done_tick !== 1'b1 && t < 3000);
         chk("b2b_mid_rd", rd_mid, 0);
         chk("b2b_done",   32'(ia.tx_done_tick), 1);
         @(negedge clk);
         chk("gap_rd", 32'(ia.fifo_rd), 1);
         chk("gap_tx", 32'(ia.tx), 1);
         @(negedge clk);
         chk("gap_tx2", 32'(ia.tx), 1);
         @(negedge clk);
         chk("start_tx", 32'(ia.tx), 0);
      end
      wait_frames(0, 3, ok);
      chk("b2b_timeout", 32'(ok), 1);
      for (int j = 0; j < 3; j++) begin
         if (fq_a.size() > 0) begin
            f = fq_a.pop_front();
            chk("b2b_frame", 32'(f.bits[9:0]), 32'(tbl[j + 1].frame));
            chk("b2b_ticks", f.ticks, 160);
            chk("b2b_stop",  32'(f.stop_bad), 0);
         end
      end
      chk("b2b_pops",  pops[0] - p0, 3);
      chk("b2b_dones", dones[0] - d0, 3);

      // reset during data bit 3 of 0x55; the queued 0x81 waits for release
      p0 = pops[0]; d0 = dones[0];
      @(posedge clk); #1;
      qa.push_back(8'h55); qa.push_back(8'h81); upd();
      wait_cnt(70, ok);
      chk("rst_cnt_timeout", 32'(ok), 1);
      @(negedge clk);
      chk("bit3_tx", 32'(ia.tx), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_tx",   32'(ia.tx), 1);
      chk("mid_rst_busy", 32'(ia.tx_busy), 0);
      chk("mid_rst_done", 32'(ia.tx_done_tick), 0);
      chk("mid_rst_rd",   32'(ia.fifo_rd), 0);
      repeat (2) begin
         @(negedge clk);
         chk("hold_rst_rd", 32'(ia.fifo_rd), 0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      wait_frames(0, 1, ok);
      chk("rst_next_timeout", 32'(ok), 1);
      if (ok) begin
         f = fq_a.pop_front();
         chk("rst_next_frame", 32'(f.bits[9:0]), 32'h302);
         chk("rst_next_ticks", f.ticks, 160);
      end
      chk("rst_pops",  pops[0] - p0, 2);
      chk("rst_dones", dones[0] - d0, 1);

      // 7 data bits, 2 stop bits
      p0 = pops[1]; d0 = dones[1];
      @(posedge clk); #1;
      qb.push_back(7'h41); upd();
      wait_frames(1, 1, ok);
      chk("b_timeout", 32'(ok), 1);
      if (ok) begin
         f = fq_b.pop_front();
         chk("b_frame", 32'(f.bits[8:0]), 32'h182);
         chk("b_ticks", f.ticks, 160);
         chk("b_stop",  32'(f.stop_bad), 0);
      end
      chk("b_pops",  pops[1] - p0, 1);
      chk("b_dones", dones[1] - d0, 1);

      // empty FIFO with ticks running: line stays idle
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (ia.fifo_rd !== 1'b0 || ia.tx !== 1'b1 || ia.tx_busy !== 1'b0) bad++;
      end
      chk("idle_quiet", bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
